// File: rtl/ecc_seq_pkg.sv
// Shared definitions for the ECC APB sequencer: register map, op/status
// encodings, FSM states and the fixed write-order table.
package ecc_seq_pkg;

  localparam logic [7:0] ADDR_CTRL           = 8'h00;
  localparam logic [7:0] ADDR_DATA_IN        = 8'h04;
  localparam logic [7:0] ADDR_CODEWORD_WIDTH = 8'h08;
  localparam logic [7:0] ADDR_NOISE          = 8'h0C;

  typedef enum logic [1:0] {
    OP_ENCODE  = 2'd0,
    OP_DECODE  = 2'd1,
    OP_FULL    = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_ILLEGAL = 2'd1,
    ST_TIMEOUT = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_WAIT_DONE,
    S_RESP
  } state_e;

  // Write step index -> register address; CTRL last so it starts the datapath.
  localparam logic [7:0] REG_SEQ [4] = '{ADDR_DATA_IN, ADDR_CODEWORD_WIDTH,
                                         ADDR_NOISE, ADDR_CTRL};

endpackage

// File: rtl/ecc_seq_timeout.sv
// Loadable saturating down-counter; o_expired flags the final allowed cycle.
module ecc_seq_timeout #(
  parameter int unsigned CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_en,
  input  logic [CW-1:0] i_load_val,
  output logic          o_expired
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/ecc_apb_sequencer.sv
// Turns one command into the DATA_IN/CODEWORD_WIDTH/NOISE/CTRL APB write burst,
// then waits for the datapath done pulse (or timeout) and returns a response.
module ecc_apb_sequencer
  import ecc_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned AMBA_WORD       = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [1:0]                 cmd_width,
  input  logic [AMBA_WORD-1:0]       cmd_data,
  input  logic [AMBA_WORD-1:0]       cmd_noise,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_errors,
  output logic [1:0]                 rsp_status,
  output logic                       busy,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic                       operation_done,
  input  logic [1:0]                 num_of_errors
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e                r_state, w_next;
  logic [1:0]            r_step, w_step_next;
  logic [1:0]            r_op, r_width;
  logic [AMBA_WORD-1:0]  r_data, r_noise;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [1:0]            r_rsp_errors;
  status_e               r_rsp_status;
  logic                  w_accept, w_load, w_expired, w_apb;
  logic                  w_unused;

  assign w_unused = ^PRDATA;

  ecc_seq_timeout #(.CW(CW)) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_en       (r_state == S_WAIT_DONE),
    .i_load_val (CW'(TIMEOUT_CYCLES - 1)),
    .o_expired  (w_expired)
  );

  // Gated by rst so the handshake stays closed while reset is held.
  assign cmd_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_RESP);

  always_comb begin
    w_next      = r_state;
    w_step_next = r_step;
    w_load      = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_accept) begin
        w_step_next = 2'd0;
        w_next      = (cmd_op == OP_ILLEGAL) ? S_RESP : S_SETUP;
      end
      S_SETUP: w_next = S_ACCESS;
      S_ACCESS: if (r_step == 2'd3) begin
        w_next = S_WAIT_DONE;
        w_load = 1'b1;
      end else begin
        w_next      = S_SETUP;
        w_step_next = r_step + 2'd1;
      end
      S_WAIT_DONE: if (operation_done || w_expired) w_next = S_RESP;
      S_RESP:      if (rsp_ready) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_step  <= 2'd0;
    end else begin
      r_state <= w_next;
      r_step  <= w_step_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= 2'd0;
      r_width <= 2'd0;
      r_data  <= '0;
      r_noise <= '0;
    end else if (w_accept) begin
      r_op    <= cmd_op;
      r_width <= cmd_width;
      r_data  <= cmd_data;
      r_noise <= cmd_noise;
    end
  end

  // Done takes priority over an expiring counter in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_data   <= '0;
      r_rsp_errors <= 2'd0;
      r_rsp_status <= ST_OK;
    end else if (w_accept && (cmd_op == OP_ILLEGAL)) begin
      r_rsp_data   <= '0;
      r_rsp_errors <= 2'd0;
      r_rsp_status <= ST_ILLEGAL;
    end else if (r_state == S_WAIT_DONE) begin
      if (operation_done) begin
        r_rsp_data   <= data_out;
        r_rsp_errors <= num_of_errors;
        r_rsp_status <= ST_OK;
      end else if (w_expired) begin
        r_rsp_data   <= '0;
        r_rsp_errors <= 2'd0;
        r_rsp_status <= ST_TIMEOUT;
      end
    end
  end

  assign rsp_data   = r_rsp_data;
  assign rsp_errors = r_rsp_errors;
  assign rsp_status = r_rsp_status;

  assign w_apb   = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign PSEL    = w_apb;
  assign PENABLE = (r_state == S_ACCESS);
  assign PWRITE  = w_apb;
  assign PADDR   = w_apb ? AMBA_ADDR_WIDTH'(REG_SEQ[r_step]) : '0;

  always_comb begin
    PWDATA = '0;
    if (w_apb) begin
      unique case (r_step)
        2'd0: PWDATA = r_data;
        2'd1: PWDATA = AMBA_WORD'(r_width);
        2'd2: PWDATA = r_noise;
        2'd3: PWDATA = AMBA_WORD'(r_op);
        default: PWDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// Directed bench for ecc_apb_sequencer: APB burst shape, response capture,
// illegal op, timeout, mid-transfer reset and back-to-back handshake.
module tb_ecc_apb_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op, cmd_width;
  logic [31:0] cmd_data, cmd_noise;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_errors, rsp_status;
  logic        busy;
  logic [19:0] PADDR;
  logic [31:0] PWDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PRDATA;
  logic [31:0] data_out;
  logic        operation_done;
  logic [1:0]  num_of_errors;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ecc_apb_sequencer #(
    .DATA_WIDTH      (32),
    .AMBA_ADDR_WIDTH (20),
    .AMBA_WORD       (32),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_width      (cmd_width),
    .cmd_data       (cmd_data),
    .cmd_noise      (cmd_noise),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_errors     (rsp_errors),
    .rsp_status     (rsp_status),
    .busy           (busy),
    .PADDR          (PADDR),
    .PWDATA         (PWDATA),
    .PSEL           (PSEL),
    .PENABLE        (PENABLE),
    .PWRITE         (PWRITE),
    .PRDATA         (PRDATA),
    .data_out       (data_out),
    .operation_done (operation_done),
    .num_of_errors  (num_of_errors)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [1:0] w,
                         input logic [31:0] d, input logic [31:0] n);
    cmd_op    = op;
    cmd_width = w;
    cmd_data  = d;
    cmd_noise = n;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !cmd_ready; i++) tick();
    check("cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Leaves the bench at the first WAIT_DONE sample point.
  task automatic expect_writes(input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3);
    logic [19:0] a [4];
    logic [31:0] d [4];
    a = '{20'h04, 20'h08, 20'h0C, 20'h00};
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("setup%0d_psel", i), {PSEL, PENABLE, PWRITE}, 3'b101);
      check($sformatf("setup%0d_paddr", i), PADDR, a[i]);
      check($sformatf("setup%0d_pwdata", i), PWDATA, d[i]);
      tick();
      check($sformatf("access%0d_psel", i), {PSEL, PENABLE, PWRITE}, 3'b111);
      check($sformatf("access%0d_paddr", i), PADDR, a[i]);
      check($sformatf("access%0d_pwdata", i), PWDATA, d[i]);
      tick();
    end
    check("wait_apb_idle", {PSEL, PENABLE, PWRITE}, 3'b000);
    check("wait_busy", {busy, rsp_valid}, 2'b10);
  endtask

  task automatic finish_done(input logic [31:0] dout, input logic [1:0] nerr);
    repeat (4) tick();
    data_out       = dout;
    num_of_errors  = nerr;
    operation_done = 1'b1;
    tick();
    operation_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_width = 2'd0;
    cmd_data = '0; cmd_noise = '0; rsp_ready = 1'b0;
    PRDATA = '0; data_out = '0; operation_done = 1'b0; num_of_errors = 2'd0;

    repeat (2) tick();
    check("rst_apb", {PSEL, PENABLE, PWRITE}, 3'b000);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp", {rsp_valid, rsp_errors, rsp_status}, 5'b0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_ready_busy", {cmd_ready, busy}, 2'b00);
    rst = 1'b0;
    tick();
    check("idle_ready", {cmd_ready, busy}, 2'b10);

    // Encode
    run_cmd(2'd0, 2'd0, 32'h0000_00A5, 32'h0);
    expect_writes(32'h0000_00A5, 32'h0, 32'h0, 32'h0);
    finish_done(32'h0000_02A5, 2'd0);
    check("enc_rsp_valid", rsp_valid, 1);
    check("enc_rsp_data", rsp_data, 32'h2A5);
    check("enc_rsp_status", rsp_status, 0);
    check("enc_rsp_errors", rsp_errors, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("enc_back_idle", {rsp_valid, cmd_ready, busy}, 3'b010);

    // Decode with one error, response held while rsp_ready=0
    run_cmd(2'd1, 2'd1, 32'h1234_5678, 32'h0000_0004);
    expect_writes(32'h1234_5678, 32'h1, 32'h4, 32'h1);
    finish_done(32'h0000_00A5, 2'd1);
    data_out = 32'hFFFF_0000;
    num_of_errors = 2'd3;
    for (int i = 0; i < 3; i++) begin
      operation_done = (i == 1);
      check($sformatf("dec_hold%0d_valid", i), rsp_valid, 1);
      check($sformatf("dec_hold%0d_data", i), rsp_data, 32'hA5);
      check($sformatf("dec_hold%0d_err_st", i), {rsp_errors, rsp_status}, 4'b0100);
      tick();
    end
    operation_done = 1'b0;
    check("dec_still_resp", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("dec_back_idle", {rsp_valid, cmd_ready}, 2'b01);

    // Illegal op
    run_cmd(2'd3, 2'd0, 32'hFFFF_FFFF, 32'h0);
    check("ill_psel", PSEL, 0);
    check("ill_rsp_valid", rsp_valid, 1);
    check("ill_status", rsp_status, 1);
    check("ill_data", rsp_data, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("ill_back_idle", {rsp_valid, cmd_ready, PSEL}, 3'b010);

    // Timeout with stray done afterwards
    data_out = 32'hDEAD_BEEF;
    num_of_errors = 2'd2;
    run_cmd(2'd2, 2'd2, 32'h0000_0055, 32'h0000_0003);
    expect_writes(32'h55, 32'h2, 32'h3, 32'h2);
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("to_wait%0d", k), {busy, rsp_valid}, 2'b10);
      tick();
    end
    check("to_rsp_valid", rsp_valid, 1);
    check("to_status", rsp_status, 2);
    check("to_data", rsp_data, 0);
    check("to_errors", rsp_errors, 0);
    operation_done = 1'b1;
    tick();
    operation_done = 1'b0;
    check("to_stray_status", rsp_status, 2);
    check("to_stray_data", rsp_data, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("to_back_idle", {rsp_valid, cmd_ready}, 2'b01);

    // Reset during NOISE ACCESS
    run_cmd(2'd0, 2'd1, 32'h0000_0011, 32'h0000_0022);
    repeat (5) tick();
    check("mid_noise_access", {PSEL, PENABLE, PADDR}, {2'b11, 20'h0C});
    rst = 1'b1;
    #1;
    check("mid_rst_apb", {PSEL, PENABLE, PWRITE}, 3'b000);
    check("mid_rst_paddr", PADDR, 0);
    check("mid_rst_busy", {busy, cmd_ready}, 2'b00);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", {cmd_ready, busy, PSEL}, 3'b100);
    run_cmd(2'd0, 2'd0, 32'h0000_00A5, 32'h0);
    expect_writes(32'h0000_00A5, 32'h0, 32'h0, 32'h0);
    finish_done(32'h0000_02A5, 2'd0);
    check("post_rst_rsp", {rsp_valid, rsp_status}, 3'b100);
    check("post_rst_data", rsp_data, 32'h2A5);
    rsp_ready = 1'b1;
    tick();
    check("post_rst_idle2", cmd_ready, 1);

    // Back-to-back with cmd_valid and rsp_ready held high
    cmd_op = 2'd3;
    cmd_valid = 1'b1;
    check("b2b_idle0", cmd_ready, 1);
    tick();
    check("b2b_resp1", {rsp_valid, cmd_ready}, 2'b10);
    tick();
    check("b2b_idle1", {rsp_valid, cmd_ready}, 2'b01);
    tick();
    check("b2b_resp2", {rsp_valid, cmd_ready, rsp_status}, 4'b1001);
    cmd_valid = 1'b0;
    tick();
    check("b2b_end_idle", {rsp_valid, busy}, 2'b00);
    rsp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
